// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default sizing for the GCD operand sequencer.
package gcd_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 1024;
endpackage

// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: feeds operand pairs to the GCD engine over its shared bus and returns results,
// short-circuiting zero operands and aborting engine runs that never finish.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);
  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d, data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, start_q, start_d, rdy_q, rdy_d, vld_q, vld_d;
  logic             accept, a_zero, b_zero, done_ok, timeout;

  assign accept  = in_valid && state_q == S_IDLE;
  assign a_zero  = in_a == '0;
  assign b_zero  = in_b == '0;
  // a done seen in the first WAIT cycle may be left over from the previous run
  assign done_ok = gcd_done && cnt_q != '0;
  assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = !accept ? S_IDLE : (a_zero || b_zero) ? S_RESP : S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT:   state_d = (done_ok || timeout) ? S_RESP : S_WAIT;
      S_RESP:   state_d = out_ready ? S_IDLE : S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // outputs are computed from the next state so every port comes straight off a flop
  always_comb begin
    a_d     = accept ? in_a : a_q;
    b_d     = accept ? in_b : b_q;
    cnt_d   = state_q == S_WAIT ? cnt_q + CNT_W'(1) : '0;
    start_d = state_d == S_LOAD_A;
    data_d  = state_d == S_LOAD_A ? a_d : (state_d == S_LOAD_B || state_d == S_WAIT) ? b_q : '0;
    rdy_d   = state_d == S_IDLE;
    vld_d   = state_d == S_RESP;
    gcd_d   = accept ? (a_d | b_d) : gcd_q;
    err_d   = accept ? (a_zero && b_zero) : err_q;
    if (state_q == S_WAIT && (done_ok || timeout)) begin
      gcd_d = done_ok ? gcd_result : '0;
      err_d = !done_ok;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_gcd   = gcd_q;
  assign out_err   = err_q;
  assign gcd_start = start_q;
  assign gcd_data  = data_q;
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb_gcd_operand_sequencer: drives operand pairs against a behavioural GCD engine with tunable done latency
// and checks every output cycle by cycle against a transaction-level reference model.
module tb_gcd_operand_sequencer;
  localparam int W  = 16;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready, out_err, gcd_start, gcd_done;
  logic [W-1:0] in_a, in_b, out_gcd, gcd_data, gcd_result;

  gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // engine: takes A with start, B the next cycle, then pulses done in WAIT cycle eng_lat (0 = never)
  int           eng_lat = 3;
  int           ec;
  logic [1:0]   eph;
  logic [W-1:0] ea, eres;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eph  <= 2'd0;
      ec   <= 0;
      ea   <= '0;
      eres <= '0;
    end else if (gcd_start) begin
      ea  <= gcd_data;
      eph <= 2'd1;
    end else if (eph == 2'd1) begin
      eres <= ref_gcd(ea, gcd_data);
      ec   <= 1;
      eph  <= 2'd2;
    end else if (eph == 2'd2) begin
      ec <= ec + 1;
      if (ec > 60) eph <= 2'd0;
    end
  end
  assign gcd_done   = eph == 2'd2 && ec == eng_lat;
  assign gcd_result = eres;

  typedef struct {
    logic [W-1:0] a, b, g;
    logic         e, eng;
    int           acc, vcyc;
  } exp_t;

  exp_t cur;
  bit   busy = 0;
  int   cyc = 0;
  bit   ok;

  always @(negedge clk) begin
    cyc++;
    if (rst) busy = 0;
    else begin
      check("in_ready", in_ready, !busy);
      check("out_valid", out_valid, busy && cyc >= cur.vcyc);
      check("gcd_start", gcd_start, busy && cur.eng && cyc == cur.acc + 1);
      check("gcd_data", gcd_data, (!busy || !cur.eng) ? 0 : cyc == cur.acc + 1 ? cur.a :
            (cyc >= cur.acc + 2 && cyc < cur.vcyc) ? cur.b : 0);
      if (busy && out_valid) begin
        check("out_gcd", out_gcd, cur.g);
        check("out_err", out_err, cur.e);
      end
      if (out_valid && out_ready) busy = 0;
      if (in_valid && in_ready) begin
        cur.a   = in_a;
        cur.b   = in_b;
        cur.acc = cyc;
        cur.eng = in_a != 0 && in_b != 0;
        if (!cur.eng) begin
          cur.g    = in_a == 0 ? in_b : in_a;
          cur.e    = in_a == 0 && in_b == 0;
          cur.vcyc = cyc + 1;
        end else begin
          ok       = eng_lat >= 2 && eng_lat <= TO;
          cur.g    = ok ? ref_gcd(in_a, in_b) : '0;
          cur.e    = !ok;
          cur.vcyc = cyc + 3 + (ok ? eng_lat : TO);
        end
        busy = 1;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_gcd"}, out_gcd, 0);
    check({tag, "_out_err"}, out_err, 0);
    check({tag, "_gcd_start"}, gcd_start, 0);
    check({tag, "_gcd_data"}, gcd_data, 0);
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", n < 100, 1);
    @(posedge clk); #1;
  endtask

  task automatic finish_resp(input int stall);
    int n = 0;
    out_ready = stall == 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_wait", n < 100, 1);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int lat, input int stall);
    eng_lat  = lat;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    finish_resp(stall);
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12 check_reset("reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(16'd143, 16'd78, 5, 0);
    eng_lat = 4; in_a = 16'd48; in_b = 16'd18; in_valid = 1'b1;
    wait_accept();
    in_a = 16'd270; in_b = 16'd192;
    wait_accept();
    in_valid = 1'b0;
    finish_resp(0);
    send(16'd0, 16'd35, 3, 0);
    send(16'd0, 16'd0, 3, 0);
    send(16'd9, 16'd6, 0, 0);
    send(16'd9, 16'd6, 16, 0);
    send(16'd9, 16'd6, 1, 0);
    send(16'd9, 16'd6, 17, 0);
    send(16'd9, 16'd6, 2, 0);
    eng_lat = 3; in_a = 16'd100; in_b = 16'd75; in_valid = 1'b1;
    wait_accept();
    in_a = 16'd0; in_b = 16'd7;
    finish_resp(5);
    wait_accept();
    in_valid = 1'b0;
    finish_resp(0);
    eng_lat = 0; in_a = 16'd9; in_b = 16'd6; in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("mid_reset");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    send(16'd143, 16'd78, 6, 0);
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom_range(0, 5) == 0 ? '0 : W'($urandom_range(1, 65535));
      rb = $urandom_range(0, 5) == 0 ? '0 : W'($urandom_range(1, 65535));
      if (i % 3 == 0) begin
        ra = W'($urandom_range(1, 300) * 7);
        rb = W'($urandom_range(1, 300) * 7);
      end
      send(ra, rb, $urandom_range(0, 20), $urandom_range(0, 3));
    end
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
